pcie_ss_tx_arb: RTL and testbench
=================================

Name: pcie_ss_tx_arb

Overview:
- Packet-atomic round-robin arbiter that shares the single PCIe subsystem TX AXI-S port between NUM_SRC host-side sources, e.g. DM requests, MMIO completions and VDM.
- Sits in fim_clk directly in front of the subsystem TX sink.
- Supports a pause request so FLR and reset sequencing can drain the port at a packet boundary.
- Output is registered: one-stage pipeline, full throughput.

Parameters:
- NUM_SRC, 3, number of requesters (2..8).
- DATA_W, 512, tdata width in bits.
- USER_W, 10, tuser width in bits.
- KEEP_W, DATA_W/8, tkeep width (derived; not overridable).

Ports:
- fim_clk  input  1  clock.
- fim_rst_n  input  1  asynchronous active-low reset.
- src_tvalid  input  NUM_SRC  per-source beat valid.
- src_tdata  input  NUM_SRC*DATA_W  per-source data; source i occupies slice i.
- src_tkeep  input  NUM_SRC*KEEP_W  per-source byte enables.
- src_tuser  input  NUM_SRC*USER_W  per-source sideband.
- src_tlast  input  NUM_SRC  per-source end of packet.
- src_tready  output  NUM_SRC  per-source ready.
- tx_tvalid  output  1  beat valid toward subsystem.
- tx_tdata  output  DATA_W  data toward subsystem.
- tx_tkeep  output  KEEP_W  byte enables toward subsystem.
- tx_tuser  output  USER_W  sideband toward subsystem.
- tx_tlast  output  1  end of packet toward subsystem.
- tx_tready  input  1  subsystem ready.
- pause_req  input  1  stop granting new packets.
- pause_ack  output  1  paused and fully drained.
- grant_id  output  $clog2(NUM_SRC)  index of the current or last granted source.
- pkt_active  output  1  a packet is mid-transfer (locked).

Behaviour:
- Reset values: every tx_* output 0, src_tready 0, pause_ack 0, grant_id 0, pkt_active 0. Internal round-robin pointer resets to 0, so source 0 has top priority first.
- Reset is asynchronous. Assertion mid-packet drops the packet: tx_tvalid falls immediately and no truncation beat is emitted.
- Output register: out_free = !tx_tvalid | tx_tready. Latency from source beat accept to tx_tvalid is 1 cycle.
- Full throughput: back-to-back beats, including across packet boundaries, with no bubble.
- State IDLE:
  - If pause_req=0 and any src_tvalid=1, select the first valid source scanning ptr, ptr+1, ..., wrapping modulo NUM_SRC.
  - src_tready[sel] = out_free in that same cycle, so the first beat transfers in the grant cycle.
  - On accept with tlast=0: go to LOCKED with grant_id=sel.
  - On accept with tlast=1 (single-beat packet): stay in IDLE and set ptr=sel+1 mod NUM_SRC.
  - grant_id updates on every accepted first beat.
- State LOCKED:
  - Only src_tready[grant_id] may be 1 (= out_free); all others are 0.
  - pause_req is ignored.
  - On an accepted beat with tlast=1: ptr=grant_id+1 mod NUM_SRC, return to IDLE.
- src_tready is never asserted for a source whose tvalid=0, except the locked source in LOCKED.
- pkt_active=1 while in LOCKED.
- pause_ack=1 when all of the following hold: pause_req=1, state is IDLE, tx_tvalid=0. It deasserts the cycle after pause_req falls.
- pause_req asserted while LOCKED: the current packet completes normally and no new grant is issued after it.
- AXI-S rules:
  - tx_* are stable while tx_tvalid=1 and tx_tready=0.
  - A source deasserting tvalid mid-packet while LOCKED does not release the lock; the output simply idles.
- Wrap-around: with ptr=NUM_SRC-1 and only source 0 valid, source 0 is granted.
- Simultaneous events: a tlast accept and a new request in the same cycle give the new grant on the next cycle; the IDLE grant is combinational from registered state.

Test Plan:
- Single source: src 1 sends a 4-beat packet with tx_tready=1 -> tx beats appear at cycles t+1..t+4 with identical data; grant_id=1; pkt_active is 1 for 3 cycles.
- Fairness: all 3 sources continuously send 2-beat packets -> output packet order 0,1,2,0,1,2; no interleaving inside a packet; 100% tx_tvalid duty.
- Backpressure: random tx_tready at 50% during a 6-beat packet from src 2 -> 6 beats delivered in order, tx_* held stable whenever stalled, no beat lost or duplicated.
- Pause: pause_req raised mid-way through a 5-beat packet from src 0 while src 1 is valid -> src 0 completes; src 1 is never readied; pause_ack=1 one cycle after the final tx beat is accepted. Dropping pause_req -> src 1 granted next.
- Wrap and single-beat: ptr=2, only src 0 valid with 1-beat packets -> src 0 granted every cycle; grant_id=0; ptr cycles 1→1.
- Reset mid-packet: assert fim_rst_n=0 on beat 2 of 4 -> tx_tvalid=0 and src_tready=0 asynchronously. After release, src 0 has priority and no residual beats appear.

Source files
------------

// File: rtl/pcie_ss_tx_arb_if.sv
// Purpose: AXI-S bundle of N lanes (flattened per-lane slices) shared by arbiter sources and TX sink.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master per lane.
interface pcie_ss_tx_arb_if #(
    parameter int N      = 1,
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    localparam int KEEP_W = DATA_W / 8;

    logic [N-1:0]        tvalid;
    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N*USER_W-1:0] tuser;
    logic [N-1:0]        tlast;
    logic [N-1:0]        tready;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/pcie_ss_tx_arb.sv
// Purpose: packet-atomic round-robin arbiter sharing the PCIe SS TX AXI-S port among NUM_SRC sources.
// Latency: 1 cycle from source beat accept to tx_tvalid; full throughput across packet boundaries.
// Backpressure: the granted source sees tready only when the output register is free; pause holds off new grants.
module pcie_ss_tx_arb #(
    parameter int NUM_SRC      = 3,
    parameter int DATA_W       = 512,
    parameter int USER_W       = 10,
    localparam int KEEP_W      = DATA_W / 8,
    localparam int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic                  fim_clk,
    input  logic                  fim_rst_n,
    pcie_ss_tx_arb_if.slave       src,
    pcie_ss_tx_arb_if.master      tx,
    input  logic                  pause_req,
    output logic                  pause_ack,
    output logic [SEL_W-1:0]      grant_id,
    output logic                  pkt_active
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic [USER_W-1:0] tuser;
        logic              tlast;
    } beat_t;

    logic [0:0]       state_q, state_nxt;
    logic [SEL_W-1:0] ptr_q, ptr_nxt;
    logic [SEL_W-1:0] grant_q, grant_nxt;
    logic [SEL_W-1:0] cand, sel_idx, cur_src;
    logic             sel_found;
    logic             can_grant;
    logic             out_free;
    logic             accept;
    logic             tx_vld_q, tx_vld_nxt;
    logic             pause_ack_q, pause_ack_nxt;
    beat_t            tx_beat_q, cur_beat;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First valid source scanning from the round-robin pointer, wrapping modulo NUM_SRC
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = SEL_W'((int'(ptr_q) + i) % NUM_SRC);
            if (!sel_found && src.tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign out_free  = !tx_vld_q || tx.tready;
    // A locked packet always owns the port; a new packet needs a requester and no pause
    assign can_grant = (state_q == ST_LOCKED) || (sel_found && !pause_req);
    assign cur_src   = (state_q == ST_LOCKED) ? grant_q : sel_idx;
    assign accept    = can_grant && out_free && src.tvalid[cur_src];

    // Ready only to the selected/locked source; forced low while reset is asserted
    always_comb begin
        src.tready = '0;
        if (fim_rst_n && can_grant) begin
            src.tready[cur_src] = out_free;
        end
    end

    // Mux the selected source's beat onto the output register input
    always_comb begin
        cur_beat.tdata = src.tdata[int'(cur_src)*DATA_W +: DATA_W];
        cur_beat.tkeep = src.tkeep[int'(cur_src)*KEEP_W +: KEEP_W];
        cur_beat.tuser = src.tuser[int'(cur_src)*USER_W +: USER_W];
        cur_beat.tlast = src.tlast[cur_src];
    end

    // Grant/lock state transitions and the acknowledge condition on next-cycle state
    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        grant_nxt = grant_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                grant_nxt = sel_idx;
                if (cur_beat.tlast) begin
                    ptr_nxt = next_idx(sel_idx);
                end else begin
                    state_nxt = ST_LOCKED;
                end
            end else if (cur_beat.tlast) begin
                ptr_nxt   = next_idx(grant_q);
                state_nxt = ST_IDLE;
            end
        end
        tx_vld_nxt    = accept || (tx_vld_q && !tx.tready);
        pause_ack_nxt = pause_req && (state_nxt == ST_IDLE) && !tx_vld_nxt;
    end

    // Arbiter state registers
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            pause_ack_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ptr_q       <= ptr_nxt;
            grant_q     <= grant_nxt;
            pause_ack_q <= pause_ack_nxt;
        end
    end

    // Output register: loads on accept, holds while the sink stalls
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            tx_vld_q  <= 1'b0;
            tx_beat_q <= '0;
        end else begin
            tx_vld_q <= tx_vld_nxt;
            if (accept) begin
                tx_beat_q <= cur_beat;
            end
        end
    end

    assign tx.tvalid  = tx_vld_q;
    assign tx.tdata   = tx_beat_q.tdata;
    assign tx.tkeep   = tx_beat_q.tkeep;
    assign tx.tuser   = tx_beat_q.tuser;
    assign tx.tlast   = tx_beat_q.tlast;
    assign pause_ack  = pause_ack_q;
    assign grant_id   = grant_q;
    assign pkt_active = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_pcie_ss_tx_arb.sv
// Purpose: scoreboard bench for pcie_ss_tx_arb: order, integrity, stall stability, pause and reset.
// Latency: expects each accepted source beat on tx one cycle later when not stalled.
// Backpressure: drives fixed or random tx_tready and checks held outputs under stall.
module tb_pcie_ss_tx_arb;
    localparam int NS = 3;
    localparam int DW = 512;
    localparam int UW = 10;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic       fim_clk   = 1'b0;
    logic       fim_rst_n = 1'b0;
    logic       pause_req = 1'b0;
    logic       pause_ack;
    logic       pkt_active;
    logic [1:0] grant_id;

    always #5 fim_clk = ~fim_clk;

    pcie_ss_tx_arb_if #(.N(NS), .DATA_W(DW), .USER_W(UW)) src_if ();
    pcie_ss_tx_arb_if #(.N(1),  .DATA_W(DW), .USER_W(UW)) tx_if ();

    pcie_ss_tx_arb #(.NUM_SRC(NS), .DATA_W(DW), .USER_W(UW)) dut (
        .fim_clk    (fim_clk),
        .fim_rst_n  (fim_rst_n),
        .src        (src_if),
        .tx         (tx_if),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .grant_id   (grant_id),
        .pkt_active (pkt_active)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       src_q[NS][$];
    beat_t       exp_q[$];
    int          gnt_log[$];
    int          open_src = -1;
    logic [NS-1:0] forbid = '0;
    bit          rnd_ready = 1'b0;
    int          acc_tot[NS];
    int          pkt_act_cnt = 0;
    int          pkt_seq = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t make_beat(input int s, input int p, input int b, input bit last);
        beat_t bt;
        for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom();
        bt.data[15:0] = {4'(s), 4'(p), 8'(b)};
        bt.keep = {$urandom(), $urandom()};
        bt.user = UW'($urandom());
        bt.last = last;
        return bt;
    endfunction

    task automatic push_pkt(input int s, input int len);
        for (int b = 0; b < len; b++) src_q[s].push_back(make_beat(s, pkt_seq, b, b == len - 1));
        pkt_seq++;
    endtask

    function automatic bit busy();
        bit r = (exp_q.size() != 0) || tx_if.tvalid;
        for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) r = 1'b1;
        return r;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(negedge fim_clk); #1;
            n++;
        end
        check_eq(tag, busy(), 0);
    endtask

    task automatic measure_duty(input string tag, input int n);
        int w = 0;
        int cnt = 0;
        @(negedge fim_clk);
        while (!tx_if.tvalid && w < 50) begin
            @(negedge fim_clk);
            w++;
        end
        for (int k = 0; k < n; k++) begin
            if (tx_if.tvalid) cnt++;
            @(negedge fim_clk);
        end
        check_eq(tag, cnt, n);
    endtask

    task automatic check_gnt_seq(input string tag, input int n, input int first, input int step);
        check_eq({tag, "_n"}, gnt_log.size(), n);
        for (int k = 0; k < n && k < gnt_log.size(); k++)
            check_eq(tag, gnt_log[k], (first + k * step) % NS);
    endtask

    // Source/sink driver plus scoreboard monitor; samples at negedge, drives 1 after posedge
    initial begin : engine
        logic [NS-1:0] acc;
        logic [NS-1:0] lock_mask;
        bit            prev_acc   = 1'b0;
        bit            prev_stall = 1'b0;
        bit            pend       = 1'b0;
        int            pend_src   = 0;
        int            n_acc;
        beat_t         e;
        logic [DW-1:0] held_d;
        logic [KW+UW:0] held_c;
        src_if.tvalid = '0;
        src_if.tdata  = '0;
        src_if.tkeep  = '0;
        src_if.tuser  = '0;
        src_if.tlast  = '0;
        tx_if.tready  = 1'b1;
        held_d = '0;
        held_c = '0;
        forever begin
            @(negedge fim_clk);
            acc = '0;
            if (!fim_rst_n) begin
                prev_acc   = 1'b0;
                prev_stall = 1'b0;
                pend       = 1'b0;
            end else begin
                if (prev_acc) check_eq("lat1", tx_if.tvalid, 1);
                if (prev_stall) begin
                    check_eq("hold_vld", tx_if.tvalid, 1);
                    check_eq("hold_dat", tx_if.tdata, held_d);
                    check_eq("hold_ctl", {tx_if.tkeep, tx_if.tuser, tx_if.tlast}, held_c);
                end
                if (pend) check_eq("grant_id", grant_id, pend_src);
                if (tx_if.tvalid && tx_if.tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("tx_dat", tx_if.tdata, e.data);
                        check_eq("tx_ctl", {tx_if.tkeep, tx_if.tuser, tx_if.tlast}, {e.keep, e.user, e.last});
                    end
                end
                prev_stall = tx_if.tvalid && !tx_if.tready;
                held_d = tx_if.tdata;
                held_c = {tx_if.tkeep, tx_if.tuser, tx_if.tlast};

                lock_mask = (open_src >= 0) ? NS'(1 << open_src) : '0;
                acc = src_if.tvalid & src_if.tready;
                check_eq("rdy_no_vld", src_if.tready & ~src_if.tvalid & ~lock_mask, 0);
                if (forbid != '0) check_eq("forbid_rdy", src_if.tready & forbid, 0);
                n_acc = $countones(acc);
                pend  = 1'b0;
                if (n_acc > 0) begin
                    check_eq("one_acc", n_acc, 1);
                    for (int i = 0; i < NS; i++) begin
                        if (acc[i] && src_q[i].size() > 0) begin
                            if (open_src >= 0) begin
                                check_eq("no_interleave", i, open_src);
                            end else begin
                                gnt_log.push_back(i);
                                pend     = 1'b1;
                                pend_src = i;
                            end
                            exp_q.push_back(src_q[i][0]);
                            acc_tot[i]++;
                            open_src = src_q[i][0].last ? -1 : i;
                        end
                    end
                end
                prev_acc = (n_acc > 0);
                if (pkt_active) pkt_act_cnt++;
            end
            @(posedge fim_clk); #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                src_if.tvalid[i] = (src_q[i].size() > 0);
                if (src_q[i].size() > 0) begin
                    src_if.tdata[i*DW +: DW] = src_q[i][0].data;
                    src_if.tkeep[i*KW +: KW] = src_q[i][0].keep;
                    src_if.tuser[i*UW +: UW] = src_q[i][0].user;
                    src_if.tlast[i]          = src_q[i][0].last;
                end
            end
            tx_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  base;
        int  w;
        bit  found;
        for (int s = 0; s < NS; s++) acc_tot[s] = 0;

        // Reset state
        repeat (3) @(negedge fim_clk);
        #1;
        check_eq("rst_tvalid", tx_if.tvalid, 0);
        check_eq("rst_tdata", tx_if.tdata, 0);
        check_eq("rst_tctl", {tx_if.tkeep, tx_if.tuser, tx_if.tlast}, 0);
        check_eq("rst_rdy", src_if.tready, 0);
        check_eq("rst_pause_ack", pause_ack, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_pkt_active", pkt_active, 0);
        @(posedge fim_clk); #2;
        fim_rst_n = 1'b1;

        // Fairness: all sources, two 2-beat packets each
        @(posedge fim_clk); #2;
        gnt_log.delete();
        for (int p = 0; p < 2; p++) for (int s = 0; s < NS; s++) push_pkt(s, 2);
        measure_duty("fair_duty", 12);
        wait_done("fair_done", 100);
        check_gnt_seq("fair_order", 6, 0, 1);

        // Single source 1, 4-beat packet
        @(posedge fim_clk); #2;
        gnt_log.delete();
        pkt_act_cnt = 0;
        push_pkt(1, 4);
        measure_duty("single_duty", 4);
        wait_done("single_done", 100);
        check_gnt_seq("single_order", 1, 1, 0);
        check_eq("single_pkt_active", pkt_act_cnt, 3);
        check_eq("single_grant_id", grant_id, 1);

        // Backpressure: 6-beat packet from src 2 with random sink ready
        @(posedge fim_clk); #2;
        gnt_log.delete();
        rnd_ready = 1'b1;
        push_pkt(2, 6);
        wait_done("bp_done", 300);
        rnd_ready = 1'b0;
        check_gnt_seq("bp_order", 1, 2, 0);

        // Pause during a 5-beat packet from src 0 while src 1 waits
        @(posedge fim_clk); #2;
        gnt_log.delete();
        forbid = 3'b010;
        base = acc_tot[0];
        push_pkt(0, 5);
        push_pkt(1, 2);
        w = 0;
        while (acc_tot[0] - base < 2 && w < 50) begin
            @(negedge fim_clk); #1;
            w++;
        end
        @(posedge fim_clk); #2;
        pause_req = 1'b1;
        found = 1'b0;
        w = 0;
        while (!found && w < 50) begin
            @(negedge fim_clk);
            if (tx_if.tvalid && tx_if.tready && tx_if.tlast) found = 1'b1;
            w++;
        end
        check_eq("pause_last_seen", found, 1);
        check_eq("pause_ack_early", pause_ack, 0);
        @(negedge fim_clk);
        check_eq("pause_ack_set", pause_ack, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge fim_clk);
            check_eq("pause_ack_hold", pause_ack, 1);
            check_eq("pause_no_grant", pkt_active, 0);
        end
        @(posedge fim_clk); #2;
        pause_req = 1'b0;
        forbid    = '0;
        @(negedge fim_clk);
        check_eq("pause_ack_lag", pause_ack, 1);
        @(negedge fim_clk);
        check_eq("pause_ack_clr", pause_ack, 0);
        wait_done("pause_done", 100);
        check_gnt_seq("pause_order", 2, 0, 1);

        // Wrap: pointer at 2, only src 0 with single-beat packets
        @(posedge fim_clk); #2;
        gnt_log.delete();
        pkt_act_cnt = 0;
        for (int k = 0; k < 5; k++) push_pkt(0, 1);
        measure_duty("wrap_duty", 5);
        wait_done("wrap_done", 100);
        check_gnt_seq("wrap_order", 5, 0, 0);
        check_eq("wrap_pkt_active", pkt_act_cnt, 0);
        check_eq("wrap_grant_id", grant_id, 0);

        // Reset in the middle of a 4-beat packet from src 0
        @(posedge fim_clk); #2;
        gnt_log.delete();
        base = acc_tot[0];
        push_pkt(0, 4);
        w = 0;
        while (acc_tot[0] - base < 1 && w < 50) begin
            @(negedge fim_clk); #1;
            w++;
        end
        @(negedge fim_clk); #2;
        fim_rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tvalid", tx_if.tvalid, 0);
        check_eq("rst_mid_rdy", src_if.tready, 0);
        check_eq("rst_mid_pkt_active", pkt_active, 0);
        @(posedge fim_clk); #2;
        for (int s = 0; s < NS; s++) src_q[s].delete();
        exp_q.delete();
        gnt_log.delete();
        open_src = -1;
        repeat (2) @(posedge fim_clk);
        #2;
        fim_rst_n = 1'b1;
        @(negedge fim_clk);
        check_eq("post_rst_idle", tx_if.tvalid, 0);
        @(posedge fim_clk); #2;
        push_pkt(1, 2);
        push_pkt(0, 2);
        wait_done("post_rst_done", 100);
        check_gnt_seq("post_rst_order", 2, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
